// File: rtl/wrr_dispatch_pkg.sv
// Shared types and constants for the weighted round-robin ALU dispatcher.
//   DEF_*          : default parameter values for the dispatcher
//   OPC_OP         : major opcode of register-register integer ops
//   state_e        : dispatcher FSM states
//   is_divide()    : true for DIV/DIVU/REM/REMU
package wrr_dispatch_pkg;

    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NUM_ALUS    = 2;
    localparam int DEF_WEIGHT_W    = 4;

    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic {
        ST_STARTUP,
        ST_RUN
    } state_e;

    // funct3[2] separates the divide/remainder group from the multiplies.
    function automatic logic is_divide(input logic [6:0] opc, input logic [31:0] instr);
        return (opc == OPC_OP) && (instr[31:25] == FUNCT7_MULDIV) && instr[14];
    endfunction

endpackage

// File: rtl/wrr_pick.sv
// Max-weight selector: returns the index of the masked-in entry with the
// highest weight, lowest index winning ties.
//   weight_i : per-entry effective weight
//   mask_i   : entries allowed to compete
//   found_o  : at least one entry was allowed
//   idx_o    : winning index, N when nothing was found
module wrr_pick
    import wrr_dispatch_pkg::*;
#(
    parameter  int N     = DEF_NUM_THREADS,
    parameter  int EW    = DEF_WEIGHT_W + 1,
    localparam int IDX_W = $clog2(N + 1)
) (
    input  logic [N-1:0][EW-1:0] weight_i,
    input  logic [N-1:0]         mask_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic          found;
    logic [EW-1:0] best_w;

    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        found  = 1'b0;
        idx_o  = IDX_W'(N);
        best_w = '0;
        // Strictly-greater replacement keeps the lowest index on ties.
        for (int t = 0; t < N; t++) begin
            if (mask_i[t] && (!found || (weight_i[t] > best_w))) begin
                found  = 1'b1;
                idx_o  = IDX_W'(t);
                best_w = weight_i[t];
            end
        end
        found_o = found;
    end

endmodule

// File: rtl/wrr_dispatch.sv
// Weighted round-robin dispatcher: issues up to NUM_ALUS threads per cycle
// to ALU slots, highest effective weight first, with a divide bonus, a
// post-divide hold-off and weight rotation on every granting cycle.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : thread has an instruction to issue
//   opcode, ins : decoded opcode (0 = bubble) and raw instruction per thread
//   alu_ready   : ALU slot can accept an issue
//   grant_valid : ALU slot receives a thread this cycle
//   grant_tid   : granted thread per slot, NUM_THREADS when idle
//   thread_ack  : thread was granted to some slot this cycle
// Optional: define DISPATCH_AGING_EN to add a per-thread starvation age to
// the effective weight.
module wrr_dispatch
    import wrr_dispatch_pkg::*;
#(
    parameter  int NUM_THREADS  = DEF_NUM_THREADS,
    parameter  int NUM_ALUS     = DEF_NUM_ALUS,
    parameter  int WEIGHT_W     = DEF_WEIGHT_W,
    parameter  int DIV_HOLD     = 2,
    parameter  int DIV_BONUS    = 4,
    parameter  int STARTUP_HOLD = 2,
    localparam int TID_W        = $clog2(NUM_THREADS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_THREADS-1:0]             req_valid,
    input  logic [NUM_THREADS-1:0][6:0]        opcode,
    input  logic [NUM_THREADS-1:0][31:0]       ins,
    input  logic [NUM_ALUS-1:0]                alu_ready,
    output logic [NUM_ALUS-1:0]                grant_valid,
    output logic [NUM_ALUS-1:0][TID_W-1:0]     grant_tid,
    output logic [NUM_THREADS-1:0]             thread_ack
);

    localparam int EW     = WEIGHT_W + 1;
    localparam int HOLD_W = (DIV_HOLD > 0) ? $clog2(DIV_HOLD + 1) : 1;
    localparam int SCNT_W = (STARTUP_HOLD > 0) ? $clog2(STARTUP_HOLD + 1) : 1;
    localparam logic [EW-1:0] EFF_MAX = '1;

    state_e                                 state_q;
    logic [SCNT_W-1:0]                      startup_cnt_q;
    logic [NUM_THREADS-1:0][WEIGHT_W-1:0]   weight_q, weight_d;
    logic [NUM_THREADS-1:0][HOLD_W-1:0]     hold_q, hold_d;
`ifdef DISPATCH_AGING_EN
    logic [NUM_THREADS-1:0][WEIGHT_W-1:0]   age_q, age_d;
`endif

    logic [NUM_THREADS-1:0]                 div_t;
    logic [NUM_THREADS-1:0]                 eligible;
    logic [NUM_THREADS-1:0][EW-1:0]         eff_w;
    logic [31:0]                            sum;

    // Eligibility and saturating effective weight per thread.
    always_comb begin
        sum = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            div_t[t]    = is_divide(opcode[t], ins[t]);
            eligible[t] = req_valid[t] && (opcode[t] != '0) && (hold_q[t] == '0);
            sum = 32'(weight_q[t]) + (div_t[t] ? 32'(DIV_BONUS) : 32'd0);
`ifdef DISPATCH_AGING_EN
            sum = sum + 32'(age_q[t]);
`endif
            eff_w[t] = (sum > 32'(EFF_MAX)) ? EFF_MAX : sum[EW-1:0];
        end
    end

    // One picker per ALU; each sees the threads not taken by lower slots.
    for (genvar j = 0; j < NUM_ALUS; j++) begin : g_alu
        logic [NUM_THREADS-1:0] taken_in;
        logic [NUM_THREADS-1:0] taken_out;
        logic                   found;
        logic [TID_W-1:0]       idx;
        logic                   gv;

        if (j == 0) begin : g_first
            assign taken_in = '0;
        end else begin : g_next
            assign taken_in = g_alu[j-1].taken_out;
        end

        wrr_pick #(
            .N  (NUM_THREADS),
            .EW (EW)
        ) u_pick (
            .weight_i (eff_w),
            .mask_i   (eligible & ~taken_in),
            .found_o  (found),
            .idx_o    (idx)
        );

        // A non-ready slot stays idle and leaves its candidate to the next slot.
        assign gv           = (state_q == ST_RUN) && alu_ready[j] && found;
        assign taken_out    = taken_in | (gv ? (NUM_THREADS'(1) << idx) : '0);
        assign grant_valid[j] = gv;
        assign grant_tid[j]   = gv ? idx : TID_W'(NUM_THREADS);
    end

    always_comb begin
        thread_ack = '0;
        for (int j = 0; j < NUM_ALUS; j++) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (grant_valid[j] && (grant_tid[j] == TID_W'(t))) thread_ack[t] = 1'b1;
            end
        end
    end

    // Next-state for per-thread state; committed only in RUN.
    always_comb begin
        weight_d = weight_q;
        hold_d   = hold_q;
`ifdef DISPATCH_AGING_EN
        age_d    = age_q;
`endif
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (thread_ack[t] && div_t[t]) begin
                hold_d[t] = HOLD_W'(DIV_HOLD);
            end else if (hold_q[t] != '0) begin
                hold_d[t] = hold_q[t] - HOLD_W'(1);
            end
            // Thread t inherits the weight of t-1; thread 0 wraps from the top.
            if (|grant_valid) begin
                weight_d[t] = weight_q[(t + NUM_THREADS - 1) % NUM_THREADS];
            end
`ifdef DISPATCH_AGING_EN
            if (thread_ack[t]) begin
                age_d[t] = '0;
            end else if (eligible[t] && (age_q[t] != '1)) begin
                age_d[t] = age_q[t] + WEIGHT_W'(1);
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_STARTUP;
            startup_cnt_q <= SCNT_W'(STARTUP_HOLD);
            hold_q        <= '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                weight_q[t] <= WEIGHT_W'(NUM_THREADS - t);
            end
`ifdef DISPATCH_AGING_EN
            age_q         <= '0;
`endif
        end else begin
            case (state_q)
                ST_STARTUP: begin
                    if (startup_cnt_q <= SCNT_W'(1)) state_q <= ST_RUN;
                    else startup_cnt_q <= startup_cnt_q - SCNT_W'(1);
                end
                ST_RUN: begin
                    weight_q <= weight_d;
                    hold_q   <= hold_d;
`ifdef DISPATCH_AGING_EN
                    age_q    <= age_d;
`endif
                end
                default: state_q <= ST_STARTUP;
            endcase
        end
    end

endmodule

// File: doc/wrr_dispatch.md
WRR_DISPATCH -- requirements
Module: wrr_dispatch

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4: number of requesting hardware threads (2..8).
REQ-002 SHALL have parameter NUM_ALUS, default 2: number of ALU issue slots (1..NUM_THREADS).
REQ-003 SHALL have parameter WEIGHT_W, default 4: width of every weight value.
REQ-004 SHALL have parameter DIV_HOLD, default 2: cycles a thread is ineligible after a divide/remainder grant.
REQ-005 SHALL have parameter DIV_BONUS, default 4: weight added to a thread presenting a divide/remainder.
REQ-006 SHALL have parameter STARTUP_HOLD, default 2: cycles after reset with no grants.
REQ-007 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-009 SHALL have port req_valid, input, [NUM_THREADS]: thread t has an instruction to issue.
REQ-010 SHALL have port opcode, input, [NUM_THREADS][7]: decoded opcode field per thread; 0 = bubble.
REQ-011 SHALL have port ins, input, [NUM_THREADS][32]: raw instruction per thread.
REQ-012 SHALL have port alu_ready, input, [NUM_ALUS]: ALU j can accept an issue this cycle.
REQ-013 SHALL have port grant_valid, output, [NUM_ALUS]: ALU j receives a thread this cycle.
REQ-014 SHALL have port grant_tid, output, [NUM_ALUS][TID_W]: granted thread index; TID_W = clog2(NUM_THREADS+1); idle value = NUM_THREADS.
REQ-015 SHALL have port thread_ack, output, [NUM_THREADS]: thread t was granted to some ALU this cycle.

Function
REQ-016 SHALL run FSM STARTUP -> RUN; STARTUP counts STARTUP_HOLD cycles then moves to RUN; RUN holds until rst.
REQ-017 SHALL drive grant_valid=0, grant_tid=NUM_THREADS, thread_ack=0 in STARTUP.
REQ-018 SHALL classify a divide as opcode==7'h33, ins[31:25]==7'b0000001, ins[14]==1 (DIV/DIVU/REM/REMU).
REQ-019 SHALL mark thread t eligible when req_valid[t], opcode[t]!=0 and hold_cnt[t]==0.
REQ-020 SHALL compute effective weight = weight_reg[t] (+DIV_BONUS if divide), saturating at WEIGHT_W+1 bits all-ones.
REQ-021 SHALL allocate ALUs in ascending index; each ready ALU takes the eligible, not-yet-granted thread with highest effective weight; ties go to lowest thread index.
REQ-022 SHALL leave a non-ready ALU idle without consuming a thread; grants are combinational from inputs and registered state (zero latency).
REQ-023 SHALL never grant one thread to two ALUs in a cycle; thread_ack[t] = OR of matches on grant_tid.
REQ-024 SHALL rotate weight_reg by one position (t takes t-1, 0 takes NUM_THREADS-1) on each RUN cycle with at least one grant; no grant -> weights unchanged.
REQ-025 SHALL load hold_cnt[t]=DIV_HOLD when t is granted a divide; else decrement nonzero hold_cnt each RUN cycle.
REQ-026 SHALL treat a thread with nonzero hold_cnt as ineligible even if req_valid is high.

Reset
REQ-027 SHALL on rst: state=STARTUP, startup counter=STARTUP_HOLD, all hold_cnt=0, weight_reg[t]=NUM_THREADS-t, aging counters=0.
REQ-028 SHALL let rst asserted mid-RUN abort pending holds immediately; outputs idle from the next cycle.

Configuration
REQ-029 SHALL with DISPATCH_AGING_EN defined keep a WEIGHT_W-bit saturating age per thread: +1 when eligible and not granted, cleared on grant, added to effective weight.
REQ-030 SHALL without DISPATCH_AGING_EN contain no aging storage; effective weight per REQ-020 only.

Structure
REQ-031 SHALL place NUM_THREADS, NUM_ALUS, WEIGHT_W defaults, opcode constant 7'h33 and the divide-decode function in the shared types package.
REQ-032 SHALL instantiate one sub-module, wrr_pick, returning the max-weight eligible index from a masked weight vector; one instance per ALU, chained by grant mask.

Verification
REQ-033 SHALL check: rst then all req_valid=1 -> no grant for 2 cycles, cycle 3 grants ALU0=T0, ALU1=T1.
REQ-034 SHALL check: T2 presents DIV, others ADD, weights 4,3,2,1 -> T2 effective 6 wins ALU0; T2 not eligible next 2 cycles.
REQ-035 SHALL check: alu_ready=2'b10 -> grant_valid=2'b10, ALU1 takes top thread, ALU0 grant_tid=4.
REQ-036 SHALL check: only T3 valid for 4 grant cycles -> weights rotate each cycle, returning to 4,3,2,1 after 4.
REQ-037 SHALL check: rst asserted with hold_cnt[1]=2 -> hold cleared, outputs idle next cycle, weights 4,3,2,1.
REQ-038 SHALL check (DISPATCH_AGING_EN): T3 eligible and starved 4 cycles -> age 4, T3 granted within the following cycle.
